// File: rtl/id_issue_ctrl_pkg.sv
// Shared decode definitions for the pipeline stages.
// Provides the base-ISA opcode constants, a decoded-field record and
// helpers that say which source registers an opcode actually reads.
package id_issue_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Register-related fields of an instruction word.
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } dec_t;

  // rs1 is read by everything except the upper-immediate forms and JAL.
  function automatic logic uses_rs1(input logic [6:0] opcode);
    logic used;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: used = 1'b0;
      default:                     used = 1'b1;
    endcase
    return used;
  endfunction

  // rs2 is read only by register-register ALU ops, stores and branches.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    logic used;
    case (opcode)
      OPC_OP, OPC_STORE, OPC_BRANCH: used = 1'b1;
      default:                       used = 1'b0;
    endcase
    return used;
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register.
// Ports:
//   clk, rst            clock, async active-high reset
//   set_en_i/set_idx_i  mark a register as awaiting a load result
//   clr_en_i/clr_idx_i  writeback clears the register's pending bit
//   rd_a_idx_i/rd_a_o   read port A (rs1)
//   rd_b_idx_i/rd_b_o   read port B (rs2)
// Reads return the registered state, so a clear becomes visible the
// cycle after it arrives. A set and clear of one register in the same
// cycle leaves it pending. x0 can never be pending.
module id_scoreboard (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en_i,
  input  logic [4:0] set_idx_i,
  input  logic       clr_en_i,
  input  logic [4:0] clr_idx_i,
  input  logic [4:0] rd_a_idx_i,
  input  logic [4:0] rd_b_idx_i,
  output logic       rd_a_o,
  output logic       rd_b_o
);

  logic [31:0] pending_q;
  logic [31:0] pending_d;
  logic [31:0] set_mask_s;
  logic [31:0] clr_mask_s;

  // Next pending vector: clear first, then set, so set wins; bit 0 forced low.
  always_comb begin
    set_mask_s = set_en_i ? (32'd1 << set_idx_i) : 32'd0;
    clr_mask_s = clr_en_i ? (32'd1 << clr_idx_i) : 32'd0;
    pending_d  = ((pending_q & ~clr_mask_s) | set_mask_s) & ~32'd1;
  end

  // Pending state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 32'd0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign rd_a_o = pending_q[rd_a_idx_i];
  assign rd_b_o = pending_q[rd_b_idx_i];

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode/issue front end: a small in-order instruction buffer between
// fetch and decode, with load-use hazard detection and a stall counter.
// Ports:
//   clk, rst                   clock, async active-high reset
//   if_valid/if_instr/if_pc    fetch side offer; if_ready = buffer not full
//   id_valid/id_instr/id_pc    head instruction to issue; id_ready accepts
//   flush                      redirect: drop all buffered instructions
//   wb_valid/wb_rd             load writeback clears a pending register
//   stall_cnt                  saturating count of hazard-stalled cycles
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  output logic             if_ready,
  output logic             id_valid,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  input  logic             id_ready,
  input  logic             flush,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int PTR_W  = (DEPTH > 2) ? 2 : 1;
  localparam int CNT_BW = PTR_W + 1;
  localparam logic [CNT_BW-1:0] DEPTH_C = CNT_BW'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(DEPTH - 1);

  logic [31:0]       instr_mem_q [DEPTH];
  logic [31:0]       pc_mem_q    [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_BW-1:0] count_q, count_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic        not_empty_s;
  logic        hazard_s;
  logic        push_s;
  logic        pop_s;
  logic        pend_a_s;
  logic        pend_b_s;
  logic        sb_set_s;
  logic [31:0] head_instr_s;
  dec_t        hd_s;

  // Pointer advance with explicit wrap, so non-power-of-two depths stay correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign head_instr_s = instr_mem_q[rd_ptr_q];
  assign hd_s.opcode  = head_instr_s[6:0];
  assign hd_s.rd      = head_instr_s[11:7];
  assign hd_s.rs1     = head_instr_s[19:15];
  assign hd_s.rs2     = head_instr_s[24:20];

  assign not_empty_s = (count_q != {CNT_BW{1'b0}});
  assign hazard_s    = not_empty_s &
                       ((uses_rs1(hd_s.opcode) & pend_a_s) |
                        (uses_rs2(hd_s.opcode) & pend_b_s));

  assign if_ready = (count_q < DEPTH_C);
  assign id_valid = not_empty_s & ~hazard_s & ~flush;
  assign id_instr = head_instr_s;
  assign id_pc    = pc_mem_q[rd_ptr_q];
  assign stall_cnt = stall_q;

  assign push_s   = if_valid & if_ready & ~flush;
  assign pop_s    = id_valid & id_ready;
  // Loads to x0 never produce a usable result, so they are not tracked.
  assign sb_set_s = pop_s & (hd_s.opcode == OPC_LOAD) & (hd_s.rd != 5'd0);

  id_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (sb_set_s),
    .set_idx_i  (hd_s.rd),
    .clr_en_i   (wb_valid),
    .clr_idx_i  (wb_rd),
    .rd_a_idx_i (hd_s.rs1),
    .rd_b_idx_i (hd_s.rs2),
    .rd_a_o     (pend_a_s),
    .rd_b_o     (pend_b_s)
  );

  // Buffer bookkeeping: flush empties the buffer; otherwise push/pop update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_BW{1'b0}};
    end else begin
      wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_BW'(1);
        2'b01:   count_d = count_q - CNT_BW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Stall counter: counts buffered-but-blocked cycles, saturating at all-ones.
  always_comb begin
    if (hazard_s && !flush && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_BW{1'b0}};
      stall_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  // Buffer storage: write the fetched word and PC at the write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= 32'd0;
        pc_mem_q[i]    <= 32'd0;
      end
    end else if (push_s) begin
      instr_mem_q[wr_ptr_q] <= if_instr;
      pc_mem_q[wr_ptr_q]    <= if_pc;
    end
  end

endmodule

// File: doc/id_issue_ctrl.md
ID_ISSUE_CTRL -- requirements
Module: id_issue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 2: instruction buffer entries; legal values 2 or 4.
REQ-002 SHALL have parameter CNT_W, default 16: stall counter width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port if_valid  in  1  fetch offers an instruction.
REQ-006 SHALL have port if_instr  in  32  fetched instruction word.
REQ-007 SHALL have port if_pc  in  32  PC of the fetched instruction.
REQ-008 SHALL have port if_ready  out  1  buffer can accept; equals (count < DEPTH).
REQ-009 SHALL have port id_valid  out  1  head instruction offered to decode/issue.
REQ-010 SHALL have port id_instr  out  32  head instruction word.
REQ-011 SHALL have port id_pc  out  32  head PC.
REQ-012 SHALL have port id_ready  in  1  downstream accepts.
REQ-013 SHALL have port flush  in  1  redirect; discard buffered instructions.
REQ-014 SHALL have port wb_valid  in  1  a load result is written back.
REQ-015 SHALL have port wb_rd  in  5  destination register of that writeback.
REQ-016 SHALL have port stall_cnt  out  CNT_W  cycles lost to hazards, saturating.

Function
REQ-017 SHALL push when if_valid & if_ready & !flush; pop when id_valid & id_ready; push and pop SHALL coexist in one cycle with count unchanged.
REQ-018 SHALL have a minimum latency of 1 cycle: a word pushed in cycle N is at the head no earlier than N+1; words SHALL leave in push order.
REQ-019 SHALL wrap read/write pointers modulo DEPTH; count SHALL span 0..DEPTH.
REQ-020 SHALL extract opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20] from the head word.
REQ-021 SHALL treat rs1 as used for all opcodes except 0110111 (LUI), 0010111 (AUIPC) and 1101111 (JAL).
REQ-022 SHALL treat rs2 as used only for 0110011 (OP), 0100011 (STORE) and 1100011 (BRANCH).
REQ-023 SHALL keep a 32-bit pending scoreboard; bit 0 SHALL always read 0.
REQ-024 SHALL set pending[rd] when a 0000011 (LOAD) with rd != 0 is popped.
REQ-025 SHALL clear pending[wb_rd] when wb_valid is high; if the same register is set and cleared in one cycle, set SHALL win.
REQ-026 SHALL raise hazard when the head is valid and a used source register is pending; a clear arriving in the same cycle SHALL NOT remove the hazard until the next cycle.
REQ-027 SHALL drive id_valid = (count != 0) & !hazard & !flush, combinationally.
REQ-028 SHALL increment stall_cnt each cycle (count != 0) & hazard & !flush, saturating at all-ones.
REQ-029 On flush: count and pointers SHALL return to 0 next cycle, any same-cycle push SHALL be dropped, and no pop SHALL occur; the scoreboard SHALL be preserved.
REQ-030 SHALL make id_instr and id_pc equal the head entry whenever count != 0; their value is don't-care when count = 0.

Reset
REQ-031 On rst, asynchronously: count 0, pointers 0, scoreboard all 0, stall_cnt 0; this gives if_ready=1 and id_valid=0.
REQ-032 Reset asserted mid-operation SHALL discard buffered and pending state with no further pop; the first push SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-033 SHALL take opcode constants (LOAD, STORE, BRANCH, OP, LUI, AUIPC, JAL) from a shared package used by all pipeline stages.
REQ-034 SHALL place the scoreboard (set, clear, two read ports) in one sub-module, id_scoreboard.
REQ-035 SHALL implement the buffer inline as a register array with pointers and no other sub-modules.

Verification
REQ-036 Reset then push 3 words with id_ready=0 and DEPTH=2 -> if_ready=0 after 2 pushes, the third is held off; raise id_ready -> words pop in push order.
REQ-037 Pop lw x5, then head add x6,x5,x1 -> id_valid=0 and stall_cnt counts; wb_valid with wb_rd=5 in cycle N -> add issues in N+1.
REQ-038 lw x0 popped, then head uses x0 -> no hazard, pending[0] stays 0.
REQ-039 Pop lw x7 in the same cycle as wb_valid, wb_rd=7 -> pending[7]=1 afterwards.
REQ-040 Buffer full and a hazard present, assert flush together with if_valid -> next cycle count=0, the incoming word is dropped, pending bits are kept.
REQ-041 Hold a hazard for 2^CNT_W+3 cycles -> stall_cnt saturates at all-ones and does not wrap.
